// File: rtl/umd_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package umd_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } umd_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StSign,
      StDone
   } umd_state_e;

   function automatic logic is_div(input umd_op_e op);
      return op[2];
   endfunction

   // Remainder ops take the sign of the dividend rather than the sign product.
   function automatic logic is_rem(input umd_op_e op);
      return op[2] & op[1];
   endfunction

   function automatic logic a_signed(input umd_op_e op);
      case (op)
         OpMul, OpMulh, OpMulhsu, OpDiv, OpRem: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic b_signed(input umd_op_e op);
      case (op)
         OpMul, OpMulh, OpDiv, OpRem: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/umd_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with a final sign-fixup cycle.
module umd_iter
   import umd_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned ID_WIDTH  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [2:0]           req_op_i,
   input  logic [ID_WIDTH-1:0]  req_id_i,
   input  logic [WORD_SIZE-1:0] req_a_i,
   input  logic [WORD_SIZE-1:0] req_b_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [ID_WIDTH-1:0]  rsp_id_o,
   output logic [WORD_SIZE-1:0] rsp_result_o
);

   localparam int unsigned W    = WORD_SIZE;
   localparam int unsigned CntW = $clog2(WORD_SIZE);
   localparam logic [CntW-1:0] CntLast = CntW'(WORD_SIZE - 1);

   umd_state_e          state_q, state_d;
   umd_op_e             op_q, op_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [W-1:0]        b_mag_q, b_mag_d;
   logic                neg_q, neg_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
   logic [2*W-1:0]      acc_q, acc_d;
   logic [W-1:0]        result_q, result_d;

   umd_op_e        op_in;
   logic           a_neg, b_neg;
   logic [W-1:0]   a_mag, b_mag;
   logic [W:0]     sum, trial;
   logic [2*W-1:0] prod;
   logic [W-1:0]   sel;

   assign req_ready_o  = (state_q == StIdle);
   assign rsp_valid_o  = (state_q == StDone);
   assign rsp_id_o     = id_q;
   assign rsp_result_o = result_q;

   // Next-state, datapath step and result selection.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      id_d     = id_q;
      b_mag_d  = b_mag_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      op_in    = umd_op_e'(req_op_i);
      a_neg    = a_signed(op_in) & req_a_i[W-1];
      b_neg    = b_signed(op_in) & req_b_i[W-1];
      a_mag    = a_neg ? -req_a_i : req_a_i;
      b_mag    = b_neg ? -req_b_i : req_b_i;
      sum      = '0;
      trial    = '0;
      prod     = '0;
      sel      = '0;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i && !flush_i) begin
               op_d    = op_in;
               id_d    = req_id_i;
               b_mag_d = b_mag;
               neg_d   = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
               acc_d   = {{W{1'b0}}, a_mag};
               cnt_d   = '0;
               if (is_div(op_in) && (req_b_i == '0)) begin
                  result_d = op_in[1] ? req_a_i : '1;
                  state_d  = StDone;
               end else if (((op_in == OpDiv) || (op_in == OpRem)) &&
                            (req_a_i == {1'b1, {(W-1){1'b0}}}) && (req_b_i == '1)) begin
                  result_d = op_in[1] ? '0 : req_a_i;
                  state_d  = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (is_div(op_q)) begin
               // Shift in the next dividend bit; keep the difference if it did not borrow.
               trial = acc_q[2*W-1:W-1] - {1'b0, b_mag_q};
               if (!trial[W]) acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
               else           acc_d = {acc_q[2*W-2:0], 1'b0};
            end else begin
               sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_mag_q};
               if (acc_q[0]) acc_d = {sum, acc_q[W-1:1]};
               else          acc_d = {1'b0, acc_q[2*W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StSign;
            end
         end
         StSign: begin
            if (is_div(op_q)) begin
               sel      = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
               result_d = neg_q ? -sel : sel;
            end else begin
               prod     = neg_q ? -acc_q : acc_q;
               result_d = (op_q == OpMul) ? prod[W-1:0] : prod[2*W-1:W];
            end
            state_d = StDone;
         end
         StDone: begin
            if (rsp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Flush aborts any in-flight or pending result, even one being handshaken.
      if (flush_i && (state_q != StIdle)) begin
         state_d = StIdle;
         cnt_d   = '0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         op_q     <= OpMul;
         id_q     <= '0;
         b_mag_q  <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         id_q     <= id_d;
         b_mag_q  <= b_mag_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

endmodule
